// File: rtl/mux_sel_sampler.sv
// Drives the select of an external 2:1 mux and recovers both channels per frame.
// Optional 2-flop synchronizer on Y when MUX_SEL_SAMPLER_SYNC_EN is defined.
module mux_sel_sampler #(
    parameter int DWELL_W = 8,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               Y,
    output logic               S,
    output logic               Q0,
    output logic               Q1,
    output logic               valid,
    output logic               busy,
    output logic [FRAME_W-1:0] frames,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL0 = 2'd1,
        SEL1 = 2'd2
    } state_t;

    logic ys;

`ifdef MUX_SEL_SAMPLER_SYNC_EN
    // A dwell of 3 lets the 2-cycle synchronizer settle on the current S.
    localparam int DMIN = 3;
    logic y_meta_q, y_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_meta_q <= 1'b0;
            y_sync_q <= 1'b0;
        end else begin
            y_meta_q <= Y;
            y_sync_q <= y_meta_q;
        end
    end

    assign ys = y_sync_q;
`else
    localparam int DMIN = 1;
    assign ys = Y;
`endif

    localparam logic [DWELL_W-1:0] DMIN_W = DWELL_W'(DMIN);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] eff_q, eff_d;
    logic               q0_q, q0_d;
    logic               q1_q, q1_d;
    logic               valid_q, valid_d;
    logic [FRAME_W-1:0] frames_q, frames_d;
    logic               s_q, s_d;
    logic               busy_q, busy_d;
    logic [DWELL_W-1:0] dwell_eff;
    logic               term;

    assign dwell_eff = (dwell < DMIN_W) ? DMIN_W : dwell;
    assign term      = (cnt_q == eff_q - DWELL_W'(1));

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            eff_q    <= '0;
            q0_q     <= 1'b0;
            q1_q     <= 1'b0;
            valid_q  <= 1'b0;
            frames_q <= '0;
            s_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            eff_q    <= eff_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            valid_q  <= valid_d;
            frames_q <= frames_d;
            s_q      <= s_d;
            busy_q   <= busy_d;
        end
    end

    // Next state, dwell counter and capture path.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eff_d    = eff_q;
        q0_d     = q0_q;
        q1_d     = q1_q;
        valid_d  = 1'b0;
        frames_d = frames_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    eff_d   = dwell_eff;
                    cnt_d   = '0;
                    state_d = SEL0;
                end
            end
            SEL0: begin
                if (term) begin
                    q0_d    = ys;
                    cnt_d   = '0;
                    state_d = SEL1;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            SEL1: begin
                if (term) begin
                    q1_d     = ys;
                    valid_d  = 1'b1;
                    frames_d = frames_q + FRAME_W'(1);
                    cnt_d    = '0;
                    if (en) begin
                        eff_d   = dwell_eff;
                        state_d = SEL0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the state being entered, so S moves on that edge.
    always_comb begin
        s_d    = (state_d == SEL1);
        busy_d = (state_d != IDLE);
    end

    assign S       = s_q;
    assign Q0      = q0_q;
    assign Q1      = q1_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign frames  = frames_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mux_sel_sampler.sv
// Directed bench for mux_sel_sampler with a behavioural 2:1 mux on Y.
module tb_mux_sel_sampler;

`ifdef MUX_SEL_SAMPLER_SYNC_EN
  localparam int DMIN = 3;
`else
  localparam int DMIN = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic       d0 = 1'b0;
  logic       d1 = 1'b0;
  logic       y;
  logic       s, q0, q1, valid, busy;
  logic [7:0] frames;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mux_sel_sampler #(.DWELL_W(8), .FRAME_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .dwell(dwell), .Y(y),
    .S(s), .Q0(q0), .Q1(q1), .valid(valid), .busy(busy),
    .frames(frames), .state_o(state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  assign y = s ? d1 : d0;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int eff(input int d);
    return (d < DMIN) ? DMIN : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int at_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < budget);
    check(tag, valid, 1);
    at_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int c0, c1, c2, c3, e;
    logic act;

    // 1: async reset with no clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_S", s, 0);
    check("rst_Q0", q0, 0);
    check("rst_Q1", q1, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frames", frames, 0);
    check("rst_state", state_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 2: single frame, dwell 4
    d0 = 1'b1; d1 = 1'b0; dwell = 8'd4; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("t2_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_S%0d", i), s, (i >= 4) ? 1 : 0);
      check($sformatf("t2_nv%0d", i), valid, 0);
      @(negedge clk);
    end
    check("t2_valid", valid, 1);
    check("t2_Q0", q0, 1);
    check("t2_Q1", q1, 0);
    check("t2_busy_end", busy, 0);
    check("t2_frames", frames, 1);
    @(negedge clk);
    check("t2_valid_pulse", valid, 0);

    // 3: dwell change mid-frame takes effect at next frame
    dwell = 8'd2; en = 1'b1;
    @(negedge clk);
    c0 = cyc;
    dwell = 8'd5;
    wait_valid("t3_v1", 40, c1);
    check("t3_len1", c1 - c0, 2 * eff(2));
    wait_valid("t3_v2", 40, c2);
    check("t3_len2", c2 - c1, 2 * eff(5));
    wait_valid("t3_v3", 40, c3);
    check("t3_len3", c3 - c2, 2 * eff(5));
    en = 1'b0;
    wait_idle("t3_idle", 40);

    // 4: dwell 0 clamps to the minimum dwell
    d0 = 1'b0; d1 = 1'b1; dwell = 8'd0; en = 1'b1;
    @(negedge clk);
    e = eff(0);
    for (int i = 0; i < 4 * e; i++) begin
      check($sformatf("t4_S%0d", i), s, ((i / e) % 2));
      check($sformatf("t4_v%0d", i), valid, (i > 0 && (i % (2 * e)) == 0) ? 1 : 0);
      if (valid) begin
        check("t4_Q0", q0, 0);
        check("t4_Q1", q1, 1);
      end
      @(negedge clk);
    end
    en = 1'b0;
    wait_idle("t4_idle", 20);

    // 5: frame counter wrap
    do_reset();
    dwell = 8'd1; en = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      wait_valid("t5_v", 2 * eff(1) + 4, c1);
      if (k == 1)   check("t5_f1", frames, 1);
      if (k == 255) check("t5_f255", frames, 255);
      if (k == 256) check("t5_wrap", frames, 0);
    end
    en = 1'b0;
    wait_idle("t5_idle", 20);

    // 6: reset in the middle of SEL1 discards the frame
    do_reset();
    d0 = 1'b0; d1 = 1'b1; dwell = 8'd4; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_pre_S", s, 1);
    rst = 1'b1;
    #1;
    check("t6_S", s, 0);
    check("t6_valid", valid, 0);
    check("t6_Q1", q1, 0);
    check("t6_frames", frames, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    act = 1'b0;
    repeat (10) begin
      @(negedge clk);
      act = act | valid | busy | s;
    end
    check("t6_quiet", act, 0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("t6_restart", busy, 1);
    wait_idle("t6_idle", 20);
    check("t6_frames_end", frames, 1);
    check("t6_Q1_end", q1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
